tri_bus_arbiter: RTL and testbench

//  Upstream control stage for the tristate 2-to-1 mux (ttrimux2_1): arbitrates two bus

---
 rtl/tri_bus_pkg.sv | 41 ++++
 rtl/tri_bus_if.sv | 20 ++
 rtl/tri_bus_hold_cnt.sv | 34 +++
 rtl/tri_bus_arbiter.sv | 137 +++++++++++++
 tb/tb_tri_bus_arbiter.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/tri_bus_pkg.sv
// ----------------------------------------------------------------------------
// tri_bus_pkg
// Shared types and constants for the tristate-bus arbiter slice.
//   tb_state_t : arbiter FSM states (IDLE, OWN0, OWN1, TURN)
//   owner_t    : requester index (0 or 1)
//   *_MIN/*_MAX: legal ranges for MAX_HOLD and TURNAROUND
//   HOLD_W/TURN_W: counter widths that cover those ranges
//   arb_pick() : idle-time arbitration (single requester wins, tie -> ~last)
// ----------------------------------------------------------------------------
package tri_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2,
        TURN = 2'd3
    } tb_state_t;

    typedef logic owner_t;

    localparam int MAX_HOLD_MIN   = 1;
    localparam int MAX_HOLD_MAX   = 255;
    localparam int TURNAROUND_MIN = 1;
    localparam int TURNAROUND_MAX = 15;

    localparam int HOLD_W = 8;
    localparam int TURN_W = 4;

    // Arbitration applied in IDLE and on the last TURN cycle.
    function automatic tb_state_t arb_pick(input logic [1:0] req, input owner_t last);
        tb_state_t nxt;
        case (req)
            2'b01:   nxt = OWN0;
            2'b10:   nxt = OWN1;
            2'b11:   nxt = last ? OWN0 : OWN1;  // round-robin: the one not served last
            default: nxt = IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/tri_bus_if.sv
// ----------------------------------------------------------------------------
// tri_bus_if
// Request/grant bundle between the two bus requesters and the arbiter.
//   req   [1:0] : requester levels (driven by the requester side)
//   mux_e       : tristate mux enable
//   mux_s       : tristate mux select (current/last owner)
//   gnt   [1:0] : one-hot grant or 00
//   busy        : arbiter not idle
// Modports: master = requester side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface tri_bus_if;
    logic [1:0] req;
    logic       mux_e;
    logic       mux_s;
    logic [1:0] gnt;
    logic       busy;

    modport master (output req, input  mux_e, input  mux_s, input  gnt, input  busy);
    modport slave  (input  req, output mux_e, output mux_s, output gnt, output busy);
endinterface

// File: rtl/tri_bus_hold_cnt.sv
// ----------------------------------------------------------------------------
// tri_bus_hold_cnt
// Saturating up-counter with a "one before limit" flag.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear (priority over inc)
//   inc      : count up by one, saturating at limit
//   limit    : saturation value
//   hit      : count == limit-1
// ----------------------------------------------------------------------------
module tri_bus_hold_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic         hit
);
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != limit)) begin
            cnt_q <= cnt_q + ONE;
        end
    end

    assign hit = (cnt_q == (limit - ONE));

endmodule

// File: rtl/tri_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tri_bus_arbiter
// Round-robin arbiter for two requesters sharing a tristate 2:1 mux. Drives the
// mux enable/select as registered outputs, limits hold time under contention
// and inserts TURNAROUND dead cycles (mux_e=0) after every release.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   bus.req   : requester levels (in)
//   bus.mux_e : mux enable, 1 only while a requester owns the bus (out)
//   bus.mux_s : mux select, current/last owner (out)
//   bus.gnt   : one-hot grant, gnt[k] == mux_e && mux_s==k (out)
//   bus.busy  : 1 in OWN0/OWN1/TURN (out)
// ----------------------------------------------------------------------------
module tri_bus_arbiter
    import tri_bus_pkg::*;
#(
    parameter int MAX_HOLD   = 4,
    parameter int TURNAROUND = 1
) (
    input  logic   clk,
    input  logic   rst,
    tri_bus_if.slave bus
);

    if (MAX_HOLD < MAX_HOLD_MIN || MAX_HOLD > MAX_HOLD_MAX) begin : g_bad_hold
        $error("tri_bus_arbiter: MAX_HOLD out of range");
    end
    if (TURNAROUND < TURNAROUND_MIN || TURNAROUND > TURNAROUND_MAX) begin : g_bad_turn
        $error("tri_bus_arbiter: TURNAROUND out of range");
    end

    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
    localparam logic [TURN_W-1:0] TURN_LIM = TURN_W'(TURNAROUND);

    tb_state_t  state_q, state_d;
    logic       mux_e_q;
    owner_t     mux_s_q;
    logic [1:0] gnt_q;
    logic       busy_q;
    owner_t     last_q;

    logic   in_own;
    owner_t own_idx;
    logic   hold_hit, turn_hit;

    assign in_own  = (state_q == OWN0) || (state_q == OWN1);
    assign own_idx = (state_q == OWN1);

    // Hold counter only counts contended cycles; it is cleared whenever we are
    // not owning, so it starts at zero on every OWNx entry.
    tri_bus_hold_cnt #(.W(HOLD_W)) u_hold_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (!in_own),
        .inc   (in_own && bus.req[~own_idx]),
        .limit (HOLD_LIM),
        .hit   (hold_hit)
    );

    tri_bus_hold_cnt #(.W(TURN_W)) u_turn_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (state_q != TURN),
        .inc   (state_q == TURN),
        .limit (TURN_LIM),
        .hit   (turn_hit)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = arb_pick(bus.req, last_q);
            OWN0, OWN1: begin
                if (!bus.req[own_idx] || (bus.req[~own_idx] && hold_hit))
                    state_d = TURN;
            end
            TURN: begin
                if (turn_hit)
                    state_d = arb_pick(bus.req, last_q);
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered alongside
    // it; mux_s/last only move on OWNx entry, so select is stable through TURN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mux_e_q <= 1'b0;
            mux_s_q <= 1'b0;
            gnt_q   <= 2'b00;
            busy_q  <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            mux_e_q <= (state_d == OWN0) || (state_d == OWN1);
            gnt_q   <= {state_d == OWN1, state_d == OWN0};
            busy_q  <= (state_d != IDLE);
            if (state_d == OWN0) begin
                mux_s_q <= 1'b0;
                last_q  <= 1'b0;
            end else if (state_d == OWN1) begin
                mux_s_q <= 1'b1;
                last_q  <= 1'b1;
            end
        end
    end

    assign bus.mux_e = mux_e_q;
    assign bus.mux_s = mux_s_q;
    assign bus.gnt   = gnt_q;
    assign bus.busy  = busy_q;

    // gap_q: consecutive mux_e=0 cycles preceding the current cycle.
    logic [4:0] gap_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_q <= 5'd31;
        end else if (mux_e_q) begin
            gap_q <= 5'd0;
        end else if (gap_q != 5'd31) begin
            gap_q <= gap_q + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (gnt_q != 2'b11) else $error("tri_bus_arbiter: gnt not one-hot");
            assert (mux_e_q == (|gnt_q)) else $error("tri_bus_arbiter: mux_e disagrees with gnt");
            assert (!(mux_e_q && gap_q != 5'd0) || (int'(gap_q) >= TURNAROUND))
                else $error("tri_bus_arbiter: turnaround gap too short");
        end
    end

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_tri_bus_arbiter
// Table-driven bench for tri_bus_arbiter (MAX_HOLD=4, TURNAROUND=1). Each row
// holds the inputs sampled at one rising edge and the outputs expected just
// after it. Expected values pass through a scoreboard queue.
// ----------------------------------------------------------------------------
module tb_tri_bus_arbiter;

    localparam int TURNAROUND = 1;

    logic clk = 1'b0;
    logic rst;

    tri_bus_if bus();

    tri_bus_arbiter #(.MAX_HOLD(4), .TURNAROUND(TURNAROUND)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic       e;
        logic       s;
        logic [1:0] gnt;
        logic       busy;
    } vec_t;

    typedef struct {
        int         idx;
        logic       e;
        logic       s;
        logic [1:0] gnt;
        logic       busy;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    task automatic add(input int n, input logic r, input logic [1:0] q,
                       input logic e, input logic s, input logic [1:0] g, input logic b);
        vec_t v;
        v.rst = r; v.req = q; v.e = e; v.s = s; v.gnt = g; v.busy = b;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [1:0] act, input logic [1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s step=%0d actual=%b required=%b", name, idx, act, req);
        end
    endtask

    initial begin
        exp_t       x;
        logic [1:0] prev_gnt;
        int         zero_run;
        bit         gap_valid;

        rst      = 1'b1;
        bus.req  = 2'b00;
        prev_gnt = 2'b00;
        zero_run = 0;
        gap_valid = 1'b0;

        // Reset held with req=11: everything stays quiet.
        add(2, 1, 2'b11, 0, 0, 2'b00, 0);
        // Single requester 0 for 5 cycles, then release: TURN then IDLE.
        add(5, 0, 2'b01, 1, 0, 2'b01, 1);
        add(1, 0, 2'b00, 0, 0, 2'b00, 1);
        add(2, 0, 2'b00, 0, 0, 2'b00, 0);
        // Re-grant of the same requester still passes through TURN.
        add(1, 0, 2'b01, 1, 0, 2'b01, 1);
        add(1, 0, 2'b00, 0, 0, 2'b00, 1);
        add(1, 0, 2'b01, 1, 0, 2'b01, 1);
        add(1, 0, 2'b00, 0, 0, 2'b00, 1);
        add(1, 0, 2'b00, 0, 0, 2'b00, 0);
        // Late contender: requester 1 alone, then requester 0 joins.
        add(10, 0, 2'b10, 1, 1, 2'b10, 1);
        add(3,  0, 2'b11, 1, 1, 2'b10, 1);
        add(1,  0, 2'b11, 0, 1, 2'b00, 1);
        add(1,  0, 2'b11, 1, 0, 2'b01, 1);
        add(1,  0, 2'b00, 0, 0, 2'b00, 1);
        add(1,  0, 2'b00, 0, 0, 2'b00, 0);
        // Idle tie after requester 0 was served last goes to requester 1;
        // select keeps the last owner through TURN and IDLE.
        add(1, 0, 2'b11, 1, 1, 2'b10, 1);
        add(1, 0, 2'b00, 0, 1, 2'b00, 1);
        add(1, 0, 2'b00, 0, 1, 2'b00, 0);
        // Reset in the middle of an OWN1 grant.
        add(3, 0, 2'b10, 1, 1, 2'b10, 1);
        add(1, 1, 2'b10, 0, 0, 2'b00, 0);
        // Contention from reset release: 01 x4, 00, 10 x4, 00, repeating.
        for (int j = 0; j < 20; j++) begin
            case (j % 10)
                0, 1, 2, 3: add(1, 0, 2'b11, 1, 0, 2'b01, 1);
                4:          add(1, 0, 2'b11, 0, 0, 2'b00, 1);
                9:          add(1, 0, 2'b11, 0, 1, 2'b00, 1);
                default:    add(1, 0, 2'b11, 1, 1, 2'b10, 1);
            endcase
        end
        // Uncontended hold for 50 cycles, then release.
        add(1,  1, 2'b00, 0, 0, 2'b00, 0);
        add(50, 0, 2'b01, 1, 0, 2'b01, 1);
        add(1,  0, 2'b00, 0, 0, 2'b00, 1);
        add(1,  0, 2'b00, 0, 0, 2'b00, 0);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            exp_t ex;
            rst     = vecs[i].rst;
            bus.req = vecs[i].req;
            ex.idx = i; ex.e = vecs[i].e; ex.s = vecs[i].s;
            ex.gnt = vecs[i].gnt; ex.busy = vecs[i].busy;
            sb.push_back(ex);

            @(posedge clk);
            #1;
            x = sb.pop_front();
            chk("mux_e", x.idx, {1'b0, bus.mux_e}, {1'b0, x.e});
            chk("mux_s", x.idx, {1'b0, bus.mux_s}, {1'b0, x.s});
            chk("gnt",   x.idx, bus.gnt,           x.gnt);
            chk("busy",  x.idx, {1'b0, bus.busy},  {1'b0, x.busy});

            checks++;
            if (bus.gnt === 2'b11) begin
                failures++;
                $display("FAIL gnt_onehot step=%0d actual=%b required=not 11", i, bus.gnt);
            end

            if (vecs[i].rst) begin
                gap_valid = 1'b0;
                zero_run  = 0;
            end else if (bus.gnt != 2'b00) begin
                if (prev_gnt == 2'b00 && gap_valid) begin
                    checks++;
                    if (zero_run < TURNAROUND) begin
                        failures++;
                        $display("FAIL turn_gap step=%0d actual=%0d required>=%0d",
                                 i, zero_run, TURNAROUND);
                    end
                end
                zero_run  = 0;
                gap_valid = 1'b1;
            end else begin
                zero_run++;
            end
            prev_gnt = bus.gnt;
        end

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

endmodule
